store_buffer_arbiter: RTL and testbench

- Single-port data-memory scheduler for the advanced CPU core.
- Holds committed stores in an internal circular store buffer and drains them to the data SRAM-like port.
- Shares that one port with the MEM-stage load path.
- Blocks loads that alias a pending store; forces a drain on full or on request.

---
 rtl/store_buffer_arbiter_if.sv | 51 +++++
 rtl/store_buffer_arbiter.sv | 143 ++++++++++++++
 tb/tb_store_buffer_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_arbiter_if.sv
// Bus bundle for the store buffer arbiter: store/load requester side and the
// single data-memory port. The arbiter uses the slave modport.
interface store_buffer_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int PTR_WIDTH  = 2
);
    logic                      st_valid;
    logic                      st_ready;
    logic [ADDR_WIDTH-1:0]     st_addr;
    logic [DATA_WIDTH-1:0]     st_wdata;
    logic [DATA_WIDTH/8-1:0]   st_wstrb;

    logic                      ld_valid;
    logic                      ld_ready;
    logic [ADDR_WIDTH-1:0]     ld_addr;
    logic                      ld_rvalid;
    logic [DATA_WIDTH-1:0]     ld_rdata;

    logic                      drain_req;

    logic                      mem_req;
    logic                      mem_wr;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH/8-1:0]   mem_wstrb;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic                      mem_addr_ok;
    logic                      mem_data_ok;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    logic                      sb_empty;
    logic [PTR_WIDTH:0]        sb_count;

    modport master (
        output st_valid, st_addr, st_wdata, st_wstrb,
        output ld_valid, ld_addr, drain_req,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  st_ready, ld_ready, ld_rvalid, ld_rdata,
        input  mem_req, mem_wr, mem_addr, mem_wstrb, mem_wdata,
        input  sb_empty, sb_count
    );

    modport slave (
        input  st_valid, st_addr, st_wdata, st_wstrb,
        input  ld_valid, ld_addr, drain_req,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output st_ready, ld_ready, ld_rvalid, ld_rdata,
        output mem_req, mem_wr, mem_addr, mem_wstrb, mem_wdata,
        output sb_empty, sb_count
    );
endinterface

// File: rtl/store_buffer_arbiter.sv
// Circular store buffer plus single-port memory scheduler shared with the load
// path; aliased loads wait until the matching stores have drained.
module store_buffer_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SB_DEPTH   = 4,
    parameter int PTR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    store_buffer_arbiter_if.slave bus
);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_DATA
    } state_e;

    state_e                  state_q, state_d;

    logic [ADDR_WIDTH-1:0]   sb_addr_q [SB_DEPTH];
    logic [DATA_WIDTH-1:0]   sb_data_q [SB_DEPTH];
    logic [STRB_W-1:0]       sb_strb_q [SB_DEPTH];
    logic [SB_DEPTH-1:0]     sb_vld_q;
    logic [PTR_WIDTH-1:0]    head_q, tail_q;
    logic [PTR_WIDTH:0]      count_q;

    logic [ADDR_WIDTH-1:0]   ld_addr_q;
    logic                    ld_rvalid_q;
    logic [DATA_WIDTH-1:0]   ld_rdata_q;

    logic                    full, empty, st_ready, st_fire, deq;
    logic                    ld_hit, ld_accept, mem_req, mem_wr;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(SB_DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    assign full     = (count_q == (PTR_WIDTH+1)'(SB_DEPTH));
    assign empty    = (count_q == '0);
    assign st_ready = resetn && !full;
    assign st_fire  = bus.st_valid && st_ready;
    assign deq      = (state_q == WR_DATA) && bus.mem_data_ok;

    // A store accepted in the same cycle is older than the load and aliases too.
    always_comb begin
        ld_hit = st_fire && (bus.st_addr[ADDR_WIDTH-1:2] == bus.ld_addr[ADDR_WIDTH-1:2]);
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_vld_q[i] && (sb_addr_q[i][ADDR_WIDTH-1:2] == bus.ld_addr[ADDR_WIDTH-1:2]))
                ld_hit = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        ld_accept = 1'b0;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((full || bus.drain_req) && !empty) begin
                    state_d = WR_ADDR;
                end else if (bus.ld_valid && !ld_hit) begin
                    ld_accept = resetn;
                    state_d   = RD_ADDR;
                end else if (!empty) begin
                    state_d = WR_ADDR;
                end
            end
            RD_ADDR: begin
                mem_req = 1'b1;
                if (bus.mem_addr_ok) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (bus.mem_data_ok) state_d = IDLE;
            end
            WR_ADDR: begin
                mem_req = 1'b1;
                mem_wr  = 1'b1;
                if (bus.mem_addr_ok) state_d = WR_DATA;
            end
            WR_DATA: begin
                if (bus.mem_data_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            sb_vld_q    <= '0;
            ld_rvalid_q <= 1'b0;
            ld_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (st_fire) begin
                tail_q           <= ptr_inc(tail_q);
                sb_vld_q[tail_q] <= 1'b1;
            end
            if (deq) begin
                head_q           <= ptr_inc(head_q);
                sb_vld_q[head_q] <= 1'b0;
            end
            unique case ({st_fire, deq})
                2'b10:   count_q <= count_q + (PTR_WIDTH+1)'(1);
                2'b01:   count_q <= count_q - (PTR_WIDTH+1)'(1);
                default: ;
            endcase
            ld_rvalid_q <= (state_q == RD_DATA) && bus.mem_data_ok;
            if ((state_q == RD_DATA) && bus.mem_data_ok) ld_rdata_q <= bus.mem_rdata;
        end
    end

    // Payload storage carries no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (st_fire) begin
            sb_addr_q[tail_q] <= bus.st_addr;
            sb_data_q[tail_q] <= bus.st_wdata;
            sb_strb_q[tail_q] <= bus.st_wstrb;
        end
        if (ld_accept) ld_addr_q <= bus.ld_addr;
    end

    assign bus.st_ready  = st_ready;
    assign bus.ld_ready  = ld_accept;
    assign bus.ld_rvalid = ld_rvalid_q;
    assign bus.ld_rdata  = ld_rdata_q;
    assign bus.mem_req   = mem_req;
    assign bus.mem_wr    = mem_wr;
    assign bus.mem_addr  = (state_q == RD_ADDR) ? ld_addr_q : sb_addr_q[head_q];
    assign bus.mem_wdata = sb_data_q[head_q];
    assign bus.mem_wstrb = mem_wr ? sb_strb_q[head_q] : '0;
    assign bus.sb_empty  = empty;
    assign bus.sb_count  = count_q;
endmodule

// File: tb/tb_store_buffer_arbiter.sv
// Directed and randomized bench for store_buffer_arbiter, checked against an
// architectural memory image, a FIFO of expected writes and a load scoreboard.
`timescale 1ns/1ps
module tb_store_buffer_arbiter;
    localparam int AW = 32, DW = 32, SBD = 4, PW = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    store_buffer_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PTR_WIDTH(PW)) bus ();

    store_buffer_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SB_DEPTH(SBD), .PTR_WIDTH(PW)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } req_t;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_img  [int];
    logic [31:0] arch_img [int];
    req_t        log_q     [$];
    req_t        exp_wr_q  [$];
    logic [31:0] exp_ld_q  [$];

    bit   mem_en    = 1'b0;
    bit   data_hold = 1'b0;
    int   addr_dly  = 0;
    int   wait_cnt  = 0;
    bit   resp_pend = 1'b0;
    req_t cur;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input int w);
        return (32'(w) * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] mem_get(input int w);
        return mem_img.exists(w) ? mem_img[w] : init_val(w);
    endfunction

    function automatic logic [31:0] arch_get(input int w);
        return arch_img.exists(w) ? arch_img[w] : init_val(w);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Memory responder: addr_ok after addr_dly cycles of mem_req, data_ok one cycle later.
    initial begin
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
        forever begin
            @(negedge clk);
            bus.mem_addr_ok = 1'b0;
            bus.mem_data_ok = 1'b0;
            if (!resetn) begin
                resp_pend = 1'b0;
                wait_cnt  = 0;
                continue;
            end
            if (resp_pend) begin
                if (!data_hold) begin
                    bus.mem_data_ok = 1'b1;
                    resp_pend       = 1'b0;
                    if (cur.wr)
                        mem_img[int'(cur.addr >> 2)] = merge(mem_get(int'(cur.addr >> 2)), cur.data, cur.strb);
                    else
                        bus.mem_rdata = mem_get(int'(cur.addr >> 2));
                end
            end else if (bus.mem_req && mem_en) begin
                if (wait_cnt >= addr_dly) begin
                    bus.mem_addr_ok = 1'b1;
                    wait_cnt  = 0;
                    resp_pend = 1'b1;
                    cur = '{wr: bus.mem_wr, addr: bus.mem_addr, data: bus.mem_wdata, strb: bus.mem_wstrb};
                    log_q.push_back(cur);
                    if (cur.wr) begin
                        if (exp_wr_q.size() == 0) begin
                            check("wr_unexpected", 64'(cur.addr), 64'hFFFF_FFFF_FFFF_FFFF);
                        end else begin
                            check("wr_order_addr", 64'(cur.addr), 64'(exp_wr_q[0].addr));
                            check("wr_data", 64'(cur.data), 64'(exp_wr_q[0].data));
                            check("wr_strb", 64'(cur.strb), 64'(exp_wr_q[0].strb));
                            void'(exp_wr_q.pop_front());
                        end
                    end else begin
                        check("rd_wstrb_zero", 64'(cur.strb), 64'(0));
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Load-data scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && bus.ld_rvalid) begin
                if (exp_ld_q.size() == 0)
                    check("ld_rvalid_unexpected", 64'(bus.ld_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
                else
                    check("ld_rdata", 64'(bus.ld_rdata), 64'(exp_ld_q.pop_front()));
            end
        end
    end

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        arch_img[int'(a >> 2)] = merge(arch_get(int'(a >> 2)), d, s);
        exp_wr_q.push_back('{wr: 1'b1, addr: a, data: d, strb: s});
    endtask

    // Called at a falling edge; returns at the following falling edge with st_valid low.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ok;
        ok = 1'b0;
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_wdata = d;
        bus.st_wstrb = s;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (bus.st_ready) begin
                model_store(a, d, s);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.st_valid = 1'b0;
        if (!ok) check("store_timeout", 64'(0), 64'(1));
    endtask

    // Called at a falling edge; returns 1 ns after the falling edge of the ld_ready cycle.
    task automatic load_issue(input logic [31:0] a, output int waited);
        waited = -1;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (bus.ld_ready) begin
                exp_ld_q.push_back(arch_get(int'(a >> 2)));
                waited = i;
                break;
            end
            @(negedge clk);
        end
        if (waited < 0) check("load_timeout", 64'(0), 64'(1));
    endtask

    task automatic load(input logic [31:0] a);
        int w;
        load_issue(a, w);
        @(negedge clk);
        bus.ld_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (bus.sb_empty && !bus.mem_req && !resp_pend && exp_ld_q.size() == 0 && !bus.ld_valid) begin
                done = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        check("idle_reached", 64'(done), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int          w;
        logic [31:0] d [4];
        bit          st_acc, ld_acc;

        bus.st_valid  = 1'b0;
        bus.st_addr   = '0;
        bus.st_wdata  = '0;
        bus.st_wstrb  = '0;
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 32'h200;
        bus.drain_req = 1'b0;
        mem_img[32'h200 >> 2]  = 32'hDEAD_BEEF;
        arch_img[32'h200 >> 2] = 32'hDEAD_BEEF;

        // Reset state, with a load request present during reset.
        #22;
        check("rst_mem_req", 64'(bus.mem_req), 64'(0));
        check("rst_mem_wr", 64'(bus.mem_wr), 64'(0));
        check("rst_ld_ready", 64'(bus.ld_ready), 64'(0));
        check("rst_ld_rvalid", 64'(bus.ld_rvalid), 64'(0));
        check("rst_st_ready", 64'(bus.st_ready), 64'(0));
        check("rst_ld_rdata", 64'(bus.ld_rdata), 64'(0));
        check("rst_sb_empty", 64'(bus.sb_empty), 64'(1));
        check("rst_sb_count", 64'(bus.sb_count), 64'(0));
        bus.ld_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Fill the buffer with the memory stalled.
        mem_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom;
            store(32'h100 + 32'(4 * i), d[i], 4'hF);
        end
        #1;
        check("full_count", 64'(bus.sb_count), 64'(4));
        check("full_empty", 64'(bus.sb_empty), 64'(0));
        bus.st_valid = 1'b1;
        bus.st_addr  = 32'h110;
        bus.st_wdata = 32'h5555_AAAA;
        bus.st_wstrb = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("full_st_ready", 64'(bus.st_ready), 64'(0));
            @(negedge clk);
        end
        bus.st_valid = 1'b0;
        #1;
        check("held_mem_req", 64'(bus.mem_req), 64'(1));
        check("held_mem_wr", 64'(bus.mem_wr), 64'(1));
        check("held_mem_addr", 64'(bus.mem_addr), 64'(32'h100));
        check("held_mem_wstrb", 64'(bus.mem_wstrb), 64'(4'hF));
        check("held_mem_wdata", 64'(bus.mem_wdata), 64'(d[0]));
        log_q.delete();
        mem_en = 1'b1;
        wait_idle();
        check("drain1_writes", 64'(log_q.size()), 64'(4));

        // Zero-wait load on an empty buffer: request at +1, rvalid at +3.
        @(negedge clk);
        load_issue(32'h200, w);
        check("ld_lat_ready", 64'(w), 64'(0));
        @(negedge clk);
        bus.ld_valid = 1'b0;
        #1;
        check("ld_lat_req1", 64'(bus.mem_req), 64'(1));
        check("ld_lat_wr1", 64'(bus.mem_wr), 64'(0));
        check("ld_lat_addr1", 64'(bus.mem_addr), 64'(32'h200));
        @(negedge clk);
        #1;
        check("ld_lat_req2", 64'(bus.mem_req), 64'(0));
        check("ld_lat_rvalid2", 64'(bus.ld_rvalid), 64'(0));
        @(negedge clk);
        #1;
        check("ld_lat_rvalid3", 64'(bus.ld_rvalid), 64'(1));
        check("ld_lat_rdata3", 64'(bus.ld_rdata), 64'(32'hDEAD_BEEF));
        @(negedge clk);
        #1;
        check("ld_rvalid_pulse", 64'(bus.ld_rvalid), 64'(0));
        check("ld_rdata_hold", 64'(bus.ld_rdata), 64'(32'hDEAD_BEEF));
        wait_idle();

        // Aliased load waits for the pending store to drain.
        log_q.delete();
        mem_en = 1'b0;
        store(32'h104, 32'hCAFE_0104, 4'hF);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h106;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("alias_blocked", 64'(bus.ld_ready), 64'(0));
            @(negedge clk);
        end
        mem_en = 1'b1;
        load_issue(32'h106, w);
        check("alias_after_drain_count", 64'(bus.sb_count), 64'(0));
        @(negedge clk);
        bus.ld_valid = 1'b0;
        #1;
        check("alias_rd_addr", 64'(bus.mem_addr), 64'(32'h106));
        check("alias_rd_wr", 64'(bus.mem_wr), 64'(0));
        wait_idle();
        check("alias_log_size", 64'(log_q.size()), 64'(2));
        if (log_q.size() == 2) begin
            check("alias_first_is_write", 64'(log_q[0].wr), 64'(1));
            check("alias_second_addr", 64'(log_q[1].addr), 64'(32'h106));
        end

        // Load versus pending non-aliased store, without and with drain_req.
        for (int pass = 0; pass < 2; pass++) begin
            log_q.delete();
            mem_en = 1'b0;
            load(32'h500);
            store(32'h300, $urandom, 4'hF);
            bus.drain_req = (pass == 1);
            mem_en = 1'b1;
            load(32'h400);
            wait_idle();
            bus.drain_req = 1'b0;
            check("prio_log_size", 64'(log_q.size()), 64'(3));
            if (log_q.size() == 3) begin
                check("prio_first_addr", 64'(log_q[0].addr), 64'(32'h500));
                check("prio_second_addr", 64'(log_q[1].addr), pass == 0 ? 64'(32'h400) : 64'(32'h300));
                check("prio_third_addr", 64'(log_q[2].addr), pass == 0 ? 64'(32'h300) : 64'(32'h400));
            end
        end

        // Fill again (head is mid-buffer, so it wraps) and drain with slow addr_ok.
        log_q.delete();
        mem_en = 1'b0;
        for (int i = 0; i < 4; i++) store(32'h100 + 32'(4 * i), $urandom, 4'(i + 1));
        #1;
        check("wrap_full_count", 64'(bus.sb_count), 64'(4));
        addr_dly = 3;
        mem_en   = 1'b1;
        wait_idle();
        addr_dly = 0;
        check("wrap_log_size", 64'(log_q.size()), 64'(4));
        for (int i = 0; i < 4 && i < log_q.size(); i++)
            check("wrap_order", 64'(log_q[i].addr), 64'(32'h100 + 32'(4 * i)));
        check("wrap_sb_empty", 64'(bus.sb_empty), 64'(1));

        // Reset during WR_DATA.
        log_q.delete();
        data_hold = 1'b1;
        store(32'h700, 32'h1357_9BDF, 4'h3);
        for (int i = 0; i < 20 && log_q.size() == 0; i++) @(negedge clk);
        check("rst_wr_accepted", 64'(log_q.size()), 64'(1));
        @(negedge clk);
        bus.st_valid = 1'b1;
        bus.st_addr  = 32'h704;
        bus.st_wdata = 32'h0;
        bus.st_wstrb = 4'hF;
        resetn = 1'b0;
        #1;
        check("arst_mem_req", 64'(bus.mem_req), 64'(0));
        check("arst_sb_count", 64'(bus.sb_count), 64'(0));
        check("arst_st_ready", 64'(bus.st_ready), 64'(0));
        check("arst_sb_empty", 64'(bus.sb_empty), 64'(1));
        exp_wr_q.delete();
        exp_ld_q.delete();
        arch_img[32'h700 >> 2] = mem_get(32'h700 >> 2);
        bus.st_valid = 1'b0;
        data_hold    = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        log_q.delete();
        @(negedge clk);
        load_issue(32'h200, w);
        check("post_rst_ld_ready", 64'(w), 64'(0));
        @(negedge clk);
        bus.ld_valid = 1'b0;
        wait_idle();
        check("post_rst_log", 64'(log_q.size()), 64'(1));

        // Randomized mix of stores, loads and drain requests over a small address window.
        st_acc = 1'b0;
        ld_acc = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (st_acc) bus.st_valid = 1'b0;
            if (ld_acc) bus.ld_valid = 1'b0;
            if (c % 50 == 0) addr_dly = $urandom_range(0, 2);
            if (!bus.st_valid && $urandom_range(0, 2) == 0) begin
                bus.st_valid = 1'b1;
                bus.st_addr  = 32'h100 + 32'($urandom_range(0, 31));
                bus.st_wdata = $urandom;
                bus.st_wstrb = 4'($urandom_range(1, 15));
            end
            if (!bus.ld_valid && $urandom_range(0, 2) == 0) begin
                bus.ld_valid = 1'b1;
                bus.ld_addr  = 32'h100 + 32'($urandom_range(0, 31));
            end
            bus.drain_req = ($urandom_range(0, 9) == 0);
            #1;
            st_acc = bus.st_valid && bus.st_ready;
            ld_acc = bus.ld_valid && bus.ld_ready;
            if (st_acc) model_store(bus.st_addr, bus.st_wdata, bus.st_wstrb);
            if (ld_acc) exp_ld_q.push_back(arch_get(int'(bus.ld_addr >> 2)));
        end
        @(negedge clk);
        bus.st_valid  = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.drain_req = 1'b0;
        wait_idle();
        check("rand_writes_left", 64'(exp_wr_q.size()), 64'(0));
        check("rand_loads_left", 64'(exp_ld_q.size()), 64'(0));
        check("rand_sb_count", 64'(bus.sb_count), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
